// File: rtl/pfb_multichannel_decimator_deadlock_reporter_if.sv
// pfb_multichannel_decimator_deadlock_reporter_if: monitor inputs and status outputs of the deadlock reporter
interface pfb_multichannel_decimator_deadlock_reporter_if #(
    parameter int NUM_MONITORS = 4,
    parameter int ID_W         = 2,
    parameter int THRESH_W     = 16,
    parameter int CNT_W        = 32
);
    logic [NUM_MONITORS-1:0] monitor_block;
    logic [THRESH_W-1:0]     threshold;
    logic                    clear;
    logic                    deadlock;
    logic [NUM_MONITORS-1:0] deadlock_mask;
    logic [ID_W-1:0]         deadlock_id;
    logic [CNT_W-1:0]        blocked_cycles;
    logic                    irq;
    modport master (
        output monitor_block, threshold, clear,
        input  deadlock, deadlock_mask, deadlock_id, blocked_cycles, irq
    );
    modport slave (
        input  monitor_block, threshold, clear,
        output deadlock, deadlock_mask, deadlock_id, blocked_cycles, irq
    );
endinterface

// File: rtl/pfb_multichannel_decimator_deadlock_reporter.sv
// pfb_multichannel_decimator_deadlock_reporter: persistence-filtered sticky deadlock status from per-process block flags
module pfb_multichannel_decimator_deadlock_reporter #(
    parameter int NUM_MONITORS = 4,
    parameter int ID_W         = 2,
    parameter int THRESH_W     = 16,
    parameter int CNT_W        = 32
) (
    input  logic clock,
    input  logic reset_n,
    pfb_multichannel_decimator_deadlock_reporter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMING, DEADLOCK} state_t;

    state_t                  r_state, w_next;
    logic [THRESH_W-1:0]     r_run_cnt, w_run_next;
    logic                    r_deadlock, r_irq, w_enter;
    logic [NUM_MONITORS-1:0] r_mask;
    logic [ID_W-1:0]         r_id;
    logic [CNT_W-1:0]        r_blocked;
    logic                    w_any;
    logic [THRESH_W-1:0]     w_thr;
    logic [THRESH_W:0]       w_run_inc;

    function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_MONITORS-1:0] m);
        f_lowest = '0;
        for (int i = NUM_MONITORS - 1; i >= 0; i--)
            if (m[i]) f_lowest = ID_W'(i);
    endfunction

    assign w_any     = |bus.monitor_block;
    assign w_thr     = (bus.threshold == '0) ? THRESH_W'(1) : bus.threshold;
    assign w_run_inc = {1'b0, r_run_cnt} + 1'b1;

    // clear overrides everything, so w_enter is only raised when clear is low
    always_comb begin
        w_next     = r_state;
        w_run_next = r_run_cnt;
        w_enter    = 1'b0;
        if (bus.clear) begin
            w_next     = IDLE;
            w_run_next = '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    if (w_thr == THRESH_W'(1)) w_enter = 1'b1;
                    else begin
                        w_next     = ARMING;
                        w_run_next = THRESH_W'(1);
                    end
                end
                ARMING: if (!w_any) begin
                    w_next     = IDLE;
                    w_run_next = '0;
                end else if (w_run_inc >= {1'b0, w_thr}) w_enter = 1'b1;
                else w_run_next = w_run_inc[THRESH_W-1:0];
                default: ;
            endcase
            if (w_enter) begin
                w_next     = DEADLOCK;
                w_run_next = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_run_cnt  <= '0;
            r_deadlock <= 1'b0;
            r_irq      <= 1'b0;
            r_mask     <= '0;
            r_id       <= '0;
            r_blocked  <= '0;
        end else begin
            r_state    <= w_next;
            r_run_cnt  <= w_run_next;
            r_irq      <= w_enter;
            r_deadlock <= bus.clear ? 1'b0 : (w_enter | r_deadlock);
            r_mask     <= bus.clear ? '0 : w_enter ? bus.monitor_block : r_mask;
            r_id       <= bus.clear ? '0 : w_enter ? f_lowest(bus.monitor_block) : r_id;
            r_blocked  <= bus.clear ? '0 : (w_any && !(&r_blocked)) ? r_blocked + 1'b1 : r_blocked;
        end
    end

    assign bus.deadlock       = r_deadlock;
    assign bus.irq            = r_irq;
    assign bus.deadlock_mask  = r_mask;
    assign bus.deadlock_id    = r_id;
    assign bus.blocked_cycles = r_blocked;
endmodule

// File: tb/tb_pfb_multichannel_decimator_deadlock_reporter.sv
// tb_pfb_multichannel_decimator_deadlock_reporter: directed checks of filtering, stickiness, clear, saturation and reset
module tb_pfb_multichannel_decimator_deadlock_reporter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    pfb_multichannel_decimator_deadlock_reporter_if #(.NUM_MONITORS(4), .ID_W(2), .THRESH_W(16), .CNT_W(32)) bus();
    pfb_multichannel_decimator_deadlock_reporter_if #(.NUM_MONITORS(4), .ID_W(2), .THRESH_W(16), .CNT_W(4)) bus6();

    pfb_multichannel_decimator_deadlock_reporter #(.NUM_MONITORS(4), .ID_W(2), .THRESH_W(16), .CNT_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.slave)
    );
    pfb_multichannel_decimator_deadlock_reporter #(.NUM_MONITORS(4), .ID_W(2), .THRESH_W(16), .CNT_W(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .bus(bus6.slave)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic dl, input logic irq, input logic [3:0] mask,
                           input logic [1:0] id, input logic [31:0] bc);
        chk({tag, ".deadlock"}, 32'(bus.deadlock), 32'(dl));
        chk({tag, ".irq"}, 32'(bus.irq), 32'(irq));
        chk({tag, ".mask"}, 32'(bus.deadlock_mask), 32'(mask));
        chk({tag, ".id"}, 32'(bus.deadlock_id), 32'(id));
        chk({tag, ".blocked"}, bus.blocked_cycles, bc);
    endtask

    initial begin
        bus.monitor_block = '0; bus.threshold = '0; bus.clear = 1'b0;
        bus6.monitor_block = '0; bus6.threshold = 16'd100; bus6.clear = 1'b0;
        tick(2);
        chk_all("reset", 0, 0, 4'h0, 2'd0, 0);
        reset_n = 1'b1;
        tick();
        // T1: four consecutive blocked samples at threshold 4
        bus.threshold = 16'd4; bus.monitor_block = 4'b0010;
        tick(3);
        chk_all("t1_pre", 0, 0, 4'h0, 2'd0, 3);
        tick();
        chk_all("t1_det", 1, 1, 4'b0010, 2'd1, 4);
        // T3: sticky while monitors go quiet, then clear
        bus.monitor_block = '0;
        tick();
        chk("t3_irq_drop", 32'(bus.irq), 0);
        tick(9);
        chk_all("t3_hold", 1, 0, 4'b0010, 2'd1, 4);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk_all("t3_clear", 0, 0, 4'h0, 2'd0, 0);
        // T2: one idle cycle restarts the filter
        bus.monitor_block = 4'b0001; tick(3);
        bus.monitor_block = 4'b0000; tick();
        bus.monitor_block = 4'b0001; tick(3);
        chk_all("t2", 0, 0, 4'h0, 2'd0, 6);
        bus.monitor_block = '0; bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        // T4: threshold 0 behaves as 1
        bus.threshold = 16'd0; bus.monitor_block = 4'b1100;
        tick();
        chk_all("t4", 1, 1, 4'b1100, 2'd2, 1);
        bus.monitor_block = '0; bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        chk_all("t4_clear", 0, 0, 4'h0, 2'd0, 0);
        // T5: clear wins over detection on the same edge
        bus.threshold = 16'd2; bus.monitor_block = 4'b0001;
        tick();
        chk("t5_arm", 32'(bus.deadlock), 0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk_all("t5_clr", 0, 0, 4'h0, 2'd0, 0);
        tick();
        chk_all("t5_rearm", 0, 0, 4'h0, 2'd0, 1);
        tick();
        chk_all("t5_det", 1, 1, 4'b0001, 2'd0, 2);
        bus.monitor_block = '0; bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        // threshold lowered below run count while arming
        bus.threshold = 16'd5; bus.monitor_block = 4'b1000;
        tick(3);
        chk("lower_pre", 32'(bus.deadlock), 0);
        bus.threshold = 16'd2;
        tick();
        chk_all("lower_det", 1, 1, 4'b1000, 2'd3, 4);
        // T6: saturating counter then async reset mid-cycle
        bus6.monitor_block = 4'b0100;
        tick(20);
        chk("t6_sat", 32'(bus6.blocked_cycles), 15);
        chk("t6_no_dl", 32'(bus6.deadlock), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_bc", 32'(bus6.blocked_cycles), 0);
        chk_all("t6_rst_main", 0, 0, 4'h0, 2'd0, 0);
        bus.monitor_block = '0; bus6.monitor_block = '0;
        tick();
        reset_n = 1'b1;
        tick(2);
        chk_all("post_rst", 0, 0, 4'h0, 2'd0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
